// File: rtl/dmem_mmio_responder_if.sv
// Bundle of signals between the execute stage, the data-memory responder and
// the UART byte streams.
//   Request side : data_addr, data_to_memory, data_memory_we, data_memory_re
//   Response side: read_data, read_valid, stall
//   TX stream    : tx_data, tx_valid (to transmitter), tx_ready (from transmitter)
//   RX stream    : rx_data, rx_valid (from receiver), rx_ready (to receiver)
// The slave modport is the responder view; master is the requester/UART view.
interface dmem_mmio_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_to_memory;
  logic        data_memory_we;
  logic        data_memory_re;
  logic [31:0] read_data;
  logic        read_valid;
  logic        stall;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  data_addr, data_to_memory, data_memory_we, data_memory_re,
    output read_data, read_valid, stall,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );

  modport master (
    output data_addr, data_to_memory, data_memory_we, data_memory_re,
    input  read_data, read_valid, stall,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the execute stage.
//   - data_addr[31]=0: synchronous word RAM (MEM_WORDS x 32), index addr[AW+1:2].
//   - data_addr[31]=1: MMIO window decoded on addr[3:0]:
//       0x0 TX push (write), 0x4 RX pop (read), 0x8 STATUS {rx_nonempty, tx_notfull},
//       0xC access counter (only with DMEM_ACCESS_COUNT_EN), others read 0.
//   - Loads return one cycle after acceptance on read_data/read_valid.
//   - stall is raised for a TX write while TX is full, or an RX read while RX is empty.
// Ports: clk, rst_n (async active-low), bus (dmem_mmio_responder_if.slave).
// Optional macro: DMEM_ACCESS_COUNT_EN adds a saturating RAM access counter at 0xC.
module dmem_mmio_responder #(
  parameter int unsigned MEM_WORDS  = 16384,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  dmem_mmio_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = FW + 1;

  localparam logic [3:0] OffTx     = 4'h0;
  localparam logic [3:0] OffRx     = 4'h4;
  localparam logic [3:0] OffStatus = 4'h8;
`ifdef DMEM_ACCESS_COUNT_EN
  localparam logic [3:0] OffCount  = 4'hC;
`endif

  // Request decode
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        is_mmio;
  logic [3:0]  mmio_off;
  logic        rd_req;
  logic        tx_wr;
  logic        rx_rd;
  logic        stall;
  logic        accept;
  logic        rd_accept;
  logic        unused_addr;

  assign addr     = bus.data_addr;
  assign wdata    = bus.data_to_memory;
  assign we       = bus.data_memory_we;
  assign re       = bus.data_memory_re;
  assign is_mmio  = addr[31];
  assign mmio_off = addr[3:0];
  // A store takes priority over a simultaneous load.
  assign rd_req   = re & ~we;
  assign tx_wr    = we & is_mmio & (mmio_off == OffTx);
  assign rx_rd    = rd_req & is_mmio & (mmio_off == OffRx);
  // High address bits are deliberately ignored (RAM wraps).
  assign unused_addr = ^addr;

  // TX FIFO state
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wptr_q, tx_wptr_d;
  logic [PW-1:0] tx_rptr_q, tx_rptr_d;
  logic          tx_empty;
  logic          tx_full;
  logic          tx_push;
  logic          tx_pop;

  // RX FIFO state
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wptr_q, rx_wptr_d;
  logic [PW-1:0] rx_rptr_q, rx_rptr_d;
  logic          rx_empty;
  logic          rx_full;
  logic          rx_push;
  logic          rx_pop;
  logic [7:0]    rx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[FW] != tx_rptr_q[FW]) &&
                    (tx_wptr_q[FW-1:0] == tx_rptr_q[FW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[FW] != rx_rptr_q[FW]) &&
                    (rx_wptr_q[FW-1:0] == rx_rptr_q[FW-1:0]);
  assign rx_head  = rx_mem[rx_rptr_q[FW-1:0]];

  // Stall only looks at registered FIFO state, so a same-cycle pop/push
  // cannot release it until the following cycle.
  assign stall     = (tx_wr & tx_full) | (rx_rd & rx_empty);
  assign accept    = (we | re) & ~stall;
  assign rd_accept = rd_req & ~stall;

  assign tx_push = tx_wr & ~stall;
  assign tx_pop  = ~tx_empty & bus.tx_ready;
  assign rx_pop  = rx_rd & ~stall;
  assign rx_push = bus.rx_valid & ~rx_full;

  // Data RAM (contents not reset)
  logic [31:0]   ram_mem [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdata_q;

  assign ram_idx = addr[AW+1:2];
  assign ram_we  = accept & we & ~is_mmio;
  assign ram_re  = rd_accept & ~is_mmio;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= wdata;
    end
    // Only loaded on an accepted RAM read, so it also holds the last value.
    if (ram_re) begin
      ram_rdata_q <= ram_mem[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr_q[FW-1:0]] <= wdata[7:0];
    end
    if (rx_push) begin
      rx_mem[rx_wptr_q[FW-1:0]] <= bus.rx_data;
    end
  end

  // Optional RAM access counter
  logic [31:0] cnt_value;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        cnt_clr;
  logic        ram_access;

  assign cnt_clr    = we & is_mmio & (mmio_off == OffCount);
  assign ram_access = accept & ~is_mmio;
  assign cnt_value  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = 32'h0;
    end else if (ram_access && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign cnt_value = 32'h0;
`endif

  // MMIO read value for the current request
  logic [31:0] mmio_rval;
  logic        unused_cnt;

  always_comb begin
    mmio_rval = 32'h0;
    case (mmio_off)
      OffRx:     mmio_rval = {24'h0, rx_head};
      OffStatus: mmio_rval = {30'h0, ~rx_empty, ~tx_full};
`ifdef DMEM_ACCESS_COUNT_EN
      OffCount:  mmio_rval = cnt_value;
`endif
      default:   mmio_rval = 32'h0;
    endcase
  end

  assign unused_cnt = ^cnt_value;

  // Read response registers; rd_src_q selects RAM output vs. MMIO capture.
  logic        rd_valid_q, rd_valid_d;
  logic        rd_src_q, rd_src_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;

  always_comb begin
    tx_wptr_d    = tx_wptr_q;
    tx_rptr_d    = tx_rptr_q;
    rx_wptr_d    = rx_wptr_q;
    rx_rptr_d    = rx_rptr_q;
    rd_valid_d   = 1'b0;
    rd_src_d     = rd_src_q;
    mmio_rdata_d = mmio_rdata_q;

    if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
    if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);

    if (rd_accept) begin
      rd_valid_d = 1'b1;
      if (is_mmio) begin
        rd_src_d     = 1'b0;
        mmio_rdata_d = mmio_rval;
      end else begin
        rd_src_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_src_q     <= 1'b0;
      mmio_rdata_q <= 32'h0;
    end else begin
      tx_wptr_q    <= tx_wptr_d;
      tx_rptr_q    <= tx_rptr_d;
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      rd_valid_q   <= rd_valid_d;
      rd_src_q     <= rd_src_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  // Outputs
  assign bus.read_data  = rd_src_q ? ram_rdata_q : mmio_rdata_q;
  assign bus.read_valid = rd_valid_q;
  assign bus.stall      = stall;
  assign bus.tx_data    = tx_mem[tx_rptr_q[FW-1:0]];
  assign bus.tx_valid   = ~tx_empty;
  assign bus.rx_ready   = ~rx_full;

endmodule
